// File: rtl/flex_counter_multi.sv
// Bank of NUM_CH independent counters: per-channel up/down, auto-reload or one-shot,
// synchronous clear/load, wrap base START_VAL (0 or 1). All outputs are registered.
module flex_counter_multi #(
   parameter int NUM_CNT_BITS = 8,
   parameter int NUM_CH       = 4,
   parameter int START_VAL    = 0
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CH-1:0]              clear,
   input  logic [NUM_CH-1:0]              load,
   input  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val,
   input  logic [NUM_CH-1:0]              count_enable,
   input  logic [NUM_CH-1:0]              count_down,
   input  logic [NUM_CH-1:0]              one_shot,
   input  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CH*NUM_CNT_BITS-1:0] count_out,
   output logic [NUM_CH-1:0]              rollover_flag,
   output logic [NUM_CH-1:0]              wrap_pulse,
   output logic [NUM_CH-1:0]              done
);

   // Any non-zero START_VAL is treated as 1, the only other legal base.
   localparam logic [NUM_CNT_BITS-1:0] START_V = {{(NUM_CNT_BITS-1){1'b0}}, (START_VAL != 32'sd0)};
   localparam logic [NUM_CNT_BITS-1:0] ONE_V   = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic [NUM_CNT_BITS-1:0] count_q, count_d;
      logic [NUM_CNT_BITS-1:0] load_s, roll_s, term_s, reload_s;
      logic                    done_q, done_d;
      logic                    wrap_q, wrap_d;
      logic                    flag_q, flag_d;

      assign load_s   = load_val[g*NUM_CNT_BITS +: NUM_CNT_BITS];
      assign roll_s   = rollover_val[g*NUM_CNT_BITS +: NUM_CNT_BITS];
      assign term_s   = count_down[g] ? START_V : roll_s;
      assign reload_s = count_down[g] ? roll_s  : START_V;

      // Next-state: clear > load > terminal handling > step > hold.
      always_comb begin
         count_d = count_q;
         done_d  = done_q;
         wrap_d  = 1'b0;
         if (clear[g]) begin
            count_d = '0;
            done_d  = 1'b0;
         end else if (load[g]) begin
            count_d = load_s;
            done_d  = 1'b0;
         end else if (count_enable[g] && !done_q) begin
            if (count_q == term_s) begin
               if (one_shot[g]) begin
                  done_d = 1'b1;
               end else begin
                  count_d = reload_s;
                  wrap_d  = 1'b1;
               end
            end else if (count_down[g]) begin
               count_d = count_q - ONE_V;
            end else begin
               count_d = count_q + ONE_V;
            end
         end else begin
            count_d = count_q;
         end
         // Compare against the terminal of this cycle so the flag lines up with count_out.
         flag_d = (count_d == term_s);
      end

      // Channel state register.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            count_q <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            flag_q  <= 1'b0;
         end else begin
            count_q <= count_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            flag_q  <= flag_d;
         end
      end

      assign count_out[g*NUM_CNT_BITS +: NUM_CNT_BITS] = count_q;
      assign rollover_flag[g] = flag_q;
      assign wrap_pulse[g]    = wrap_q;
      assign done[g]          = done_q;
   end

endmodule

// File: tb/tb_flex_counter_multi.sv
// Bench for flex_counter_multi: two instances (START_VAL 0 and 1) on shared stimulus,
// directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_flex_counter_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  clear, load, en, dn, os;
   logic [31:0] load_val, rollover_val;
   logic [31:0] co0, co1;
   logic [3:0]  rf0, wp0, dd0, rf1, wp1, dd1;

   int total = 0;
   int bad   = 0;

   int m_cnt  [2][4];
   bit m_done [2][4];
   bit m_flag [2][4];
   bit m_wrap [2][4];

   always #5 clk = ~clk;

   flex_counter_multi #(.NUM_CNT_BITS(8), .NUM_CH(4), .START_VAL(0)) dut0 (
      .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
      .count_enable(en), .count_down(dn), .one_shot(os), .rollover_val(rollover_val),
      .count_out(co0), .rollover_flag(rf0), .wrap_pulse(wp0), .done(dd0));

   flex_counter_multi #(.NUM_CNT_BITS(8), .NUM_CH(4), .START_VAL(1)) dut1 (
      .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
      .count_enable(en), .count_down(dn), .one_shot(os), .rollover_val(rollover_val),
      .count_out(co1), .rollover_flag(rf1), .wrap_pulse(wp1), .done(dd1));

   function automatic int get_cnt(int s, int c);
      return (s == 0) ? int'(co0[c*8 +: 8]) : int'(co1[c*8 +: 8]);
   endfunction
   function automatic bit get_flag(int s, int c);
      return (s == 0) ? rf0[c] : rf1[c];
   endfunction
   function automatic bit get_wrap(int s, int c);
      return (s == 0) ? wp0[c] : wp1[c];
   endfunction
   function automatic bit get_done(int s, int c);
      return (s == 0) ? dd0[c] : dd1[c];
   endfunction

   task automatic set_rv(int c, int v);
      rollover_val[c*8 +: 8] = 8'(v);
   endtask
   task automatic set_lv(int c, int v);
      load_val[c*8 +: 8] = 8'(v);
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++)
         for (int c = 0; c < 4; c++) begin
            m_cnt[s][c] = 0; m_done[s][c] = 1'b0; m_flag[s][c] = 1'b0; m_wrap[s][c] = 1'b0;
         end
   endtask

   // Reference: base S is the instance's START_VAL; terminal/reload swap with direction.
   task automatic model_step();
      int t, r, lv, rv;
      for (int s = 0; s < 2; s++)
         for (int c = 0; c < 4; c++) begin
            lv = int'(load_val[c*8 +: 8]);
            rv = int'(rollover_val[c*8 +: 8]);
            t  = dn[c] ? s : rv;
            r  = dn[c] ? rv : s;
            m_wrap[s][c] = 1'b0;
            if (rst) begin
               m_cnt[s][c] = 0; m_done[s][c] = 1'b0;
            end else if (clear[c]) begin
               m_cnt[s][c] = 0; m_done[s][c] = 1'b0;
            end else if (load[c]) begin
               m_cnt[s][c] = lv; m_done[s][c] = 1'b0;
            end else if (en[c] && !m_done[s][c]) begin
               if (m_cnt[s][c] == t) begin
                  if (os[c]) m_done[s][c] = 1'b1;
                  else begin
                     m_cnt[s][c] = r; m_wrap[s][c] = 1'b1;
                  end
               end else if (dn[c]) m_cnt[s][c] = (m_cnt[s][c] + 255) % 256;
               else m_cnt[s][c] = (m_cnt[s][c] + 1) % 256;
            end
            m_flag[s][c] = rst ? 1'b0 : (m_cnt[s][c] == t);
         end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_inputs();
      clear = '0; load = '0; en = '0; dn = '0; os = '0;
      load_val = '0; rollover_val = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      zero_inputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      zero_inputs();
      #2;
      total++;
      if ({co0, co1, rf0, wp0, dd0, rf1, wp1, dd1} !== 88'd0) begin
         bad++;
         $display("FAIL reset_async got co0=%h co1=%h rf=%b%b wp=%b%b dd=%b%b exp all 0",
                  co0, co1, rf0, rf1, wp0, wp1, dd0, dd1);
      end
      en = 4'hF; rollover_val = 32'h0505_0505;
      @(posedge clk);
      #1;
      total++;
      if ({co0, co1, rf0, wp0, dd0, rf1, wp1, dd1} !== 88'd0) begin
         bad++;
         $display("FAIL reset_held got co0=%h co1=%h exp 0", co0, co1);
      end
      do_reset();
   endtask

   task automatic test_up_reload();
      int e;
      do_reset();
      set_rv(0, 5); en = 4'b0001;
      for (int k = 1; k <= 14; k++) begin
         tick();
         e = k % 6;
         total++;
         if (co0[7:0] !== 8'(e) || rf0[0] !== (e == 5) || wp0[0] !== (e == 0)) begin
            bad++;
            $display("FAIL up_reload k=%0d cnt got %0d exp %0d flag got %b wrap got %b",
                     k, co0[7:0], e, rf0[0], wp0[0]);
         end
      end
   endtask

   task automatic test_down_start1();
      int e;
      do_reset();
      dn = 4'b0001; set_rv(0, 4); set_lv(0, 4); load = 4'b0001; en = 4'b0001;
      tick();
      load = '0;
      total++;
      if (co1[7:0] !== 8'd4 || rf1[0] !== 1'b0 || wp1[0] !== 1'b0) begin
         bad++;
         $display("FAIL down_load cnt got %0d exp 4 flag %b wrap %b", co1[7:0], rf1[0], wp1[0]);
      end
      for (int k = 1; k <= 10; k++) begin
         tick();
         e = 4 - (k % 4);
         total++;
         if (co1[7:0] !== 8'(e) || rf1[0] !== (e == 1) || wp1[0] !== (e == 4)) begin
            bad++;
            $display("FAIL down_start1 k=%0d cnt got %0d exp %0d flag got %b wrap got %b",
                     k, co1[7:0], e, rf1[0], wp1[0]);
         end
      end
   endtask

   task automatic test_one_shot();
      int e;
      do_reset();
      os = 4'b0001; set_rv(0, 3); en = 4'b0001;
      for (int k = 1; k <= 10; k++) begin
         tick();
         e = (k < 3) ? k : 3;
         total++;
         if (co0[7:0] !== 8'(e) || dd0[0] !== (k >= 4) || rf0[0] !== (e == 3) || wp0[0] !== 1'b0) begin
            bad++;
            $display("FAIL one_shot k=%0d cnt got %0d exp %0d done got %b flag %b wrap %b",
                     k, co0[7:0], e, dd0[0], rf0[0], wp0[0]);
         end
      end
      set_lv(0, 0); load = 4'b0001;
      tick();
      load = '0;
      total++;
      if (co0[7:0] !== 8'd0 || dd0[0] !== 1'b0) begin
         bad++;
         $display("FAIL one_shot_reload cnt got %0d exp 0 done got %b exp 0", co0[7:0], dd0[0]);
      end
      tick();
      total++;
      if (co0[7:0] !== 8'd1 || dd0[0] !== 1'b0) begin
         bad++;
         $display("FAIL one_shot_resume cnt got %0d exp 1 done got %b exp 0", co0[7:0], dd0[0]);
      end
   endtask

   task automatic test_priority();
      do_reset();
      set_rv(0, 200); set_lv(0, 7); load = 4'b0001;
      tick();
      total++;
      if (co0[7:0] !== 8'd7) begin
         bad++; $display("FAIL prio_load cnt got %0d exp 7", co0[7:0]);
      end
      set_lv(0, 9); clear = 4'b0001; load = 4'b0001; en = 4'b0001;
      tick();
      total++;
      if (co0[7:0] !== 8'd0) begin
         bad++; $display("FAIL prio_clear cnt got %0d exp 0", co0[7:0]);
      end
      clear = '0;
      tick();
      total++;
      if (co0[7:0] !== 8'd9) begin
         bad++; $display("FAIL prio_load_en cnt got %0d exp 9", co0[7:0]);
      end
      load = '0;
      tick();
      total++;
      if (co0[7:0] !== 8'd10) begin
         bad++; $display("FAIL prio_count cnt got %0d exp 10", co0[7:0]);
      end
   endtask

   task automatic test_boundaries();
      int e;
      // Count above a lowered terminal runs through the modulus before wrapping.
      do_reset();
      set_rv(0, 255); set_lv(0, 200); load = 4'b0001;
      tick();
      load = '0; set_rv(0, 10); en = 4'b0001;
      for (int k = 1; k <= 66; k++) begin
         tick();
         e = (200 + k) % 256;
         total++;
         if (co0[7:0] !== 8'(e) || rf0[0] !== (e == 10) || wp0[0] !== 1'b0) begin
            bad++;
            $display("FAIL beyond_term k=%0d cnt got %0d exp %0d flag %b wrap %b",
                     k, co0[7:0], e, rf0[0], wp0[0]);
         end
      end
      tick();
      total++;
      if (co0[7:0] !== 8'd0 || wp0[0] !== 1'b1) begin
         bad++; $display("FAIL beyond_wrap cnt got %0d exp 0 wrap got %b exp 1", co0[7:0], wp0[0]);
      end
      // Down from 0 with base 1 passes through 255.
      do_reset();
      dn = 4'b0001; set_rv(0, 20); set_lv(0, 0); load = 4'b0001;
      tick();
      load = '0; en = 4'b0001;
      for (int k = 1; k <= 255; k++) begin
         tick();
         e = 256 - k;
         total++;
         if (co1[7:0] !== 8'(e) || rf1[0] !== (e == 1) || wp1[0] !== 1'b0) begin
            bad++;
            $display("FAIL down_under k=%0d cnt got %0d exp %0d flag %b wrap %b",
                     k, co1[7:0], e, rf1[0], wp1[0]);
         end
      end
      tick();
      total++;
      if (co1[7:0] !== 8'd20 || wp1[0] !== 1'b1) begin
         bad++; $display("FAIL down_reload cnt got %0d exp 20 wrap got %b exp 1", co1[7:0], wp1[0]);
      end
      // Terminal equal to base: each enable is a wrap.
      do_reset();
      set_rv(0, 0); en = 4'b0001;
      for (int k = 1; k <= 5; k++) begin
         tick();
         total++;
         if (co0[7:0] !== 8'd0 || wp0[0] !== 1'b1 || rf0[0] !== 1'b1) begin
            bad++;
            $display("FAIL t_eq_r k=%0d cnt got %0d exp 0 wrap %b flag %b exp 1 1",
                     k, co0[7:0], wp0[0], rf0[0]);
         end
      end
      en = '0;
      tick();
      total++;
      if (co0[7:0] !== 8'd0 || wp0[0] !== 1'b0) begin
         bad++; $display("FAIL t_eq_r_idle cnt got %0d wrap got %b exp 0 0", co0[7:0], wp0[0]);
      end
      do_reset();
      set_rv(0, 1); en = 4'b0001;
      for (int k = 1; k <= 4; k++) begin
         tick();
         total++;
         if (co1[7:0] !== 8'd1 || wp1[0] !== (k >= 2) || rf1[0] !== 1'b1) begin
            bad++;
            $display("FAIL t_eq_r_base1 k=%0d cnt got %0d exp 1 wrap got %b flag got %b",
                     k, co1[7:0], wp1[0], rf1[0]);
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 4; c++) set_rv(c, $urandom_range(0, 12));
      for (int cyc = 0; cyc < 800; cyc++) begin
         for (int c = 0; c < 4; c++) begin
            clear[c] = ($urandom_range(0, 31) == 0);
            load[c]  = ($urandom_range(0, 15) == 0);
            set_lv(c, $urandom_range(0, 255));
            en[c]    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) dn[c] = ~dn[c];
            if ($urandom_range(0, 29) == 0) os[c] = ~os[c];
            if ($urandom_range(0, 24) == 0)
               set_rv(c, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12));
         end
         tick();
         for (int s = 0; s < 2; s++)
            for (int c = 0; c < 4; c++) begin
               total++;
               if (get_cnt(s, c) != m_cnt[s][c] || get_flag(s, c) !== m_flag[s][c] ||
                   get_wrap(s, c) !== m_wrap[s][c] || get_done(s, c) !== m_done[s][c]) begin
                  bad++;
                  $display("FAIL random cyc=%0d inst=%0d ch=%0d cnt %0d/%0d flag %b/%b wrap %b/%b done %b/%b (got/exp)",
                           cyc, s, c, get_cnt(s, c), m_cnt[s][c], get_flag(s, c), m_flag[s][c],
                           get_wrap(s, c), m_wrap[s][c], get_done(s, c), m_done[s][c]);
               end
            end
         if (cyc == 400) begin
            #2 rst = 1'b1;
            #1;
            total++;
            if ({co0, co1, rf0, wp0, dd0, rf1, wp1, dd1} !== 88'd0) begin
               bad++;
               $display("FAIL random_rst got co0=%h co1=%h rf=%b%b wp=%b%b dd=%b%b exp all 0",
                        co0, co1, rf0, rf1, wp0, wp1, dd0, dd1);
            end
            rst = 1'b0;
            model_reset();
         end
      end
   endtask

   initial begin
      test_reset();
      test_up_reload();
      test_down_start1();
      test_one_shot();
      test_priority();
      test_boundaries();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
